divider_4bit: RTL and testbench
===============================

DIVIDER_4BIT -- requirements
Module: divider_4bit

Interface
REQ-001 The block SHALL have exactly one clock, and its reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active-low, sampled on the clk rising edge.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned dividend, the width of a 4x4 product.
REQ-006 divisor  input  4  unsigned divisor.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  single-cycle pulse when results are valid.
REQ-009 quotient  output  8  unsigned quotient, held until the next completion.
REQ-010 remainder  output  4  unsigned remainder, held until the next completion.
REQ-011 div_by_zero  output  1  high with done when the captured divisor is 0; held with the results.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE to RUN: on a clk edge with start=1 and divisor!=0, the block SHALL capture dividend and divisor, clear the partial remainder and load iteration counter = 7.
REQ-014 IDLE to DONE: on a clk edge with start=1 and divisor==0, the block SHALL skip RUN and set div_by_zero=1, quotient=8'hFF and remainder=4'hF.
REQ-015 RUN algorithm: restoring division, MSB-first, one quotient bit per cycle.
- Each cycle: shift {rem,dividend-bit}; compare against the divisor; subtract if greater or equal; shift the quotient bit in.
- Exactly 8 RUN cycles; go to DONE after counter 0.
REQ-016 Partial-remainder datapath SHALL be 5 bits wide, so no intermediate result overflows.
REQ-017 DONE SHALL last exactly one cycle, with done=1 and busy=0, then return to IDLE.
REQ-018 Normal latency: done SHALL be high on the 9th cycle after the start-sampling edge; div-by-zero latency SHALL be 1 cycle.
REQ-019 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 start SHALL be ignored in RUN and DONE: no restart and no capture. A new start is accepted in the first IDLE cycle after DONE.
REQ-021 quotient, remainder and div_by_zero SHALL update only on entry to DONE, and SHALL otherwise hold their values.
REQ-022 Changes on dividend or divisor after capture SHALL have no effect on the result.
REQ-023 For divisor!=0 the result SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor.

Reset
REQ-024 When rst_n=0 at a clk edge, state SHALL be IDLE and busy, done, div_by_zero, quotient, remainder and the counter SHALL all be 0.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse, and no partial result SHALL become visible.
REQ-026 Reset SHALL take priority over start on the same edge.

Configuration
REQ-027 Macro DIVIDER_4BIT_SELFCHECK_EN SHALL add output chk_err (1 bit).
- Defined: in DONE, recompute quotient*divisor+remainder and compare with the captured dividend. chk_err SHALL pulse with done on a mismatch. It SHALL be 0 whenever div_by_zero=1, and 0 after reset.
- Undefined: no chk_err port and no multiply logic; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package div4_pkg SHALL hold:
- the state encoding (IDLE, RUN, DONE);
- width constants DVD_W=8 and DVS_W=4;
- divide-by-zero constants Q_DZ=8'hFF and R_DZ=4'hF.
REQ-029 One sub-module, divider_4bit_step, SHALL hold one combinational restoring step:
- inputs: rem(5), next dividend bit, divisor(4);
- outputs: new rem(5), quotient bit.
REQ-030 The top level SHALL contain the FSM, counter, capture registers and the optional self-check.

Verification
REQ-031 dividend=6, divisor=3, start pulse -> done on the 9th cycle, quotient=2, remainder=0, div_by_zero=0.
REQ-032 dividend=120, divisor=10 -> quotient=12, remainder=0; then dividend=200, divisor=7 -> quotient=28, remainder=4.
REQ-033 dividend=255, divisor=1 -> quotient=255, remainder=0; dividend=5, divisor=15 -> quotient=0, remainder=5.
REQ-034 dividend=77, divisor=0 -> done 1 cycle after start, div_by_zero=1, quotient=8'hFF, remainder=4'hF.
REQ-035 start held high through RUN with dividend/divisor changed mid-run -> first result unaffected; next start accepted only after DONE.
REQ-036 rst_n=0 on the 4th RUN cycle -> busy=0, no done pulse, all outputs 0; a following 9/2 -> quotient=4, remainder=1.

Source files
------------

// File: rtl/div4_pkg.sv
// Shared definitions for the 4-bit restoring divider: FSM encoding, datapath widths
// and the fixed result returned on a divide-by-zero request.
package div4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int REM_W = DVS_W + 1;
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] CNT_FIRST = 3'd7;

    localparam logic [DVD_W-1:0] Q_DZ = 8'hFF;
    localparam logic [DVS_W-1:0] R_DZ = 4'hF;

endpackage

// File: rtl/divider_4bit_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits and emit the quotient bit.
module divider_4bit_step
    import div4_pkg::*;
(
    input  logic [REM_W-1:0] rem_i,
    input  logic             bit_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [REM_W-1:0] rem_o,
    output logic             q_o
);

    logic [REM_W-1:0] shifted;
    logic [REM_W-1:0] dvs_ext;

    always_comb begin
        shifted = {rem_i[REM_W-2:0], bit_i};
        dvs_ext = {1'b0, divisor_i};
        // A set top bit means the shifted value is at least 32, which always exceeds the divisor.
        q_o     = rem_i[REM_W-1] | (shifted >= dvs_ext);
        rem_o   = q_o ? (shifted - dvs_ext) : shifted;
    end

endmodule

// File: rtl/divider_4bit.sv
// 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// Optional macro DIVIDER_4BIT_SELFCHECK_EN adds the chk_err result self-check output.
module divider_4bit
    import div4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
`ifdef DIVIDER_4BIT_SELFCHECK_EN
    ,
    output logic             chk_err
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVD_W-1:0]   dividend_q, dividend_d;
    logic [DVS_W-1:0]   divisor_q, divisor_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [DVD_W-2:0]   qacc_q, qacc_d;
    logic [DVD_W-1:0]   quotient_q, quotient_d;
    logic [DVS_W-1:0]   remainder_q, remainder_d;
    logic               dz_q, dz_d;

    logic [REM_W-1:0]   step_rem;
    logic               step_q;

    divider_4bit_step u_step (
        .rem_i     (rem_q),
        .bit_i     (dividend_q[cnt_q]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        qacc_d      = qacc_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    rem_d      = '0;
                    qacc_d     = '0;
                    if (divisor != '0) begin
                        state_d = RUN;
                        cnt_d   = CNT_FIRST;
                    end else begin
                        state_d     = DONE;
                        quotient_d  = Q_DZ;
                        remainder_d = R_DZ;
                        dz_d        = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d  = step_rem;
                qacc_d = {qacc_q[DVD_W-3:0], step_q};
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = {qacc_q, step_q};
                    remainder_d = step_rem[DVS_W-1:0];
                    dz_d        = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and visible results are cleared by reset so an aborted run leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

    always_ff @(posedge clk) begin
        dividend_q <= dividend_d;
        divisor_q  <= divisor_d;
        rem_q      <= rem_d;
        qacc_q     <= qacc_d;
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;

`ifdef DIVIDER_4BIT_SELFCHECK_EN
    logic [12:0] recon;

    always_comb begin
        recon   = 13'(quotient_q) * 13'(divisor_q) + 13'(remainder_q);
        chk_err = (state_q == DONE) && !dz_q && (recon != 13'(dividend_q));
    end
`endif

endmodule

// File: tb/tb_divider_4bit.sv
// Directed bench for divider_4bit: expected results queued at start, compared at done.
module tb_divider_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
`ifdef DIVIDER_4BIT_SELFCHECK_EN
    logic       chk_err;
`endif

    divider_4bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`ifdef DIVIDER_4BIT_SELFCHECK_EN
        ,
        .chk_err     (chk_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q   = 8'hFF;
            e.r   = 4'hF;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = a / {4'b0, b};
            e.r   = 4'(a % {4'b0, b});
            e.dz  = 1'b0;
            e.lat = 9;
        end
        sb.push_back(e);
    endtask

    // n0 = cycles already elapsed since the start-sampling edge
    task automatic finish_div(input int n0, input string tag);
        int   n;
        exp_t e;
        n = n0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'(e.lat));
        chk({tag, "_quotient"}, 32'(quotient), 32'(e.q));
        chk({tag, "_remainder"}, 32'(remainder), 32'(e.r));
        chk({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
`ifdef DIVIDER_4BIT_SELFCHECK_EN
        chk({tag, "_chk_err"}, 32'(chk_err), 32'd0);
`endif
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_q_held"}, 32'(quotient), 32'(e.q));
        chk({tag, "_r_held"}, 32'(remainder), 32'(e.r));
    endtask

    task automatic run_div(input logic [7:0] a, input logic [3:0] b, input string tag);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        push_exp(a, b);
        tick();
        start = 1'b0;
        if (b != 4'd0) chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        finish_div(1, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;

        // Reset, with start asserted on the same edges
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd6;
        divisor  = 4'd3;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
`ifdef DIVIDER_4BIT_SELFCHECK_EN
        chk("rst_chk_err", 32'(chk_err), 32'd0);
`endif
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        run_div(8'd6, 4'd3, "d6_3");
        run_div(8'd120, 4'd10, "d120_10");
        run_div(8'd200, 4'd7, "d200_7");
        run_div(8'd255, 4'd1, "d255_1");
        run_div(8'd5, 4'd15, "d5_15");
        run_div(8'd77, 4'd0, "d77_0");
        run_div(8'd15, 4'd15, "d15_15");

        // start held high through RUN and DONE, operands changed mid-run
        dividend = 8'd100;
        divisor  = 4'd9;
        start    = 1'b1;
        push_exp(8'd100, 4'd9);
        tick();
        tick();
        tick();
        dividend = 8'd50;
        divisor  = 4'd3;
        finish_div(3, "held");
        chk("held_no_restart", 32'(busy), 32'd0);
        push_exp(8'd50, 4'd3);
        tick();
        chk("accept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        finish_div(1, "accept");

        // Reset on the 4th RUN cycle aborts the division
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_dz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        run_div(8'd9, 4'd2, "d9_2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
